round_timer_scorer: RTL and testbench

//  Companion of the score FSM. Consumes its add[1:0] / shrink outputs and generates the timeUp square wave it waits on.

---
 rtl/round_timer_scorer.sv | 145 ++++++++++++++
 tb/tb_round_timer_scorer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/round_timer_scorer.sv
// Round timer and scorer that sits beside the score FSM.
// Keeps a two-digit BCD score and a lives count. Generates the timeUp square
// wave, whose period shortens each time a shrink request arrives.
module round_timer_scorer #(
  parameter int unsigned START_PERIOD = 50_000_000,
  parameter int unsigned MIN_PERIOD   = 12_500_000,
  parameter int unsigned SHRINK_STEP  = 6_250_000,
  parameter int unsigned LIVES        = 3
) (
  input  logic        systemClock,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  add,
  input  logic        shrink,
  output logic        timeUp,
  output logic [7:0]  score_bcd,
  output logic [1:0]  lives,
  output logic        game_over,
  output logic [31:0] period_cur
);

  localparam logic [31:0] START_P = 32'(START_PERIOD);
  localparam logic [31:0] MIN_P   = 32'(MIN_PERIOD);
  localparam logic [31:0] STEP_P  = 32'(SHRINK_STEP);
  localparam logic [1:0]  LIVES_P = 2'(LIVES);

  localparam logic [1:0] ADD_MISS = 2'd0;
  localparam logic [1:0] ADD_HIT  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] period_cur_q, period_cur_d;
  logic [31:0] period_next_q, period_next_d;
  logic [7:0]  score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic        time_up_q, time_up_d;

  // Shorten the period by one step. The result never drops below the floor.
  // Compare the headroom first, so the subtraction can never wrap.
  function automatic logic [31:0] shrunk(input logic [31:0] p);
    if ((p >= MIN_P) && ((p - MIN_P) >= STEP_P)) return p - STEP_P;
    return MIN_P;
  endfunction

  // Increment a two-digit BCD value. The ones digit carries into the tens, and
  // the value holds at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s == 8'h99)        return s;
    if (s[3:0] == 4'd9)    return {s[7:4] + 4'd1, 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

  // Next-state logic: game state, round counter, period, score and lives.
  always_comb begin
    // NOTE: give every variable a default first, so that no path leaves it unassigned and infers a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    period_cur_d  = period_cur_q;
    period_next_d = period_next_q;
    score_d       = score_q;
    lives_d       = lives_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d       = ST_RUN;
          score_d       = 8'h00;
          lives_d       = LIVES_P;
          period_cur_d  = START_P;
          period_next_d = START_P;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          if (add == ADD_HIT) score_d = bcd_inc(score_q);
          if (add == ADD_MISS) begin
            if (lives_q <= 2'd1) begin
              lives_d = 2'd0;
              state_d = ST_OVER;
            end else begin
              lives_d = lives_q - 2'd1;
            end
          end
          if (shrink) period_next_d = shrunk(period_next_q);
          // A shrink only changes the period at a wrap. This keeps the round
          // running that way free of glitches.
          if (cnt_q >= period_cur_q - 32'd1) begin
            cnt_d        = '0;
            period_cur_d = period_next_q;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      ST_OVER: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Register timeUp from the next-state values. The output then matches the
    // counter and period that are visible on the same cycle.
    time_up_d = (state_d == ST_RUN) && (cnt_d >= (period_cur_d >> 1));
  end

  // State registers. The reset is asynchronous and loads the reset values immediately.
  always_ff @(posedge systemClock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      period_cur_q  <= START_P;
      period_next_q <= START_P;
      score_q       <= 8'h00;
      lives_q       <= LIVES_P;
      time_up_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      period_cur_q  <= period_cur_d;
      period_next_q <= period_next_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      time_up_q     <= time_up_d;
    end
  end

  assign timeUp     = time_up_q;
  assign score_bcd  = score_q;
  assign lives      = lives_q;
  assign game_over  = (state_q == ST_OVER);
  assign period_cur = period_cur_q;

endmodule

// File: tb/tb_round_timer_scorer.sv
// Scoreboard bench for round_timer_scorer. A driver applies stimulus and pushes
// the response a reference model expects. A monitor pops each entry and
// compares it one cycle later.
module tb_round_timer_scorer;

  localparam int START = 8;
  localparam int MINP  = 4;
  localparam int STEP  = 2;
  localparam int NLIV  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  add = 2'd2;
  logic        shrink = 1'b0;
  logic        timeUp;
  logic [7:0]  score_bcd;
  logic [1:0]  lives;
  logic        game_over;
  logic [31:0] period_cur;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        tu;
    logic [7:0]  sc;
    logic [1:0]  lv;
    logic        go;
    logic [31:0] per;
  } exp_t;

  exp_t exp_q[$];

  round_timer_scorer #(
    .START_PERIOD(START), .MIN_PERIOD(MINP), .SHRINK_STEP(STEP), .LIVES(NLIV)
  ) dut (
    .systemClock(clk),
    .reset      (reset),
    .enable     (enable),
    .add        (add),
    .shrink     (shrink),
    .timeUp     (timeUp),
    .score_bcd  (score_bcd),
    .lives      (lives),
    .game_over  (game_over),
    .period_cur (period_cur)
  );

  always #5 clk = ~clk;

  // Reference model: game phase flags, score as a plain integer, period in clocks.
  bit m_run, m_over;
  int m_score, m_lives, m_period, m_pnext, m_cnt;

  function automatic void model_reset();
    m_run = 0; m_over = 0; m_score = 0; m_lives = NLIV;
    m_period = START; m_pnext = START; m_cnt = 0;
  endfunction

  function automatic void model_step(input bit en, input int a, input bit sh);
    int old_pn;
    if (!m_run && !m_over) begin
      m_cnt = 0;
      if (en) begin
        m_run = 1; m_score = 0; m_lives = NLIV;
        m_period = START; m_pnext = START;
      end
    end else if (m_over) begin
      if (!en) begin m_over = 0; m_cnt = 0; end
    end else if (!en) begin
      m_run = 0; m_cnt = 0;
    end else begin
      if (a == 1 && m_score < 99) m_score++;
      if (a == 0) begin
        m_lives--;
        if (m_lives == 0) begin m_run = 0; m_over = 1; end
      end
      old_pn = m_pnext;
      if (sh) m_pnext = (m_pnext - STEP < MINP) ? MINP : m_pnext - STEP;
      if (m_cnt == m_period - 1) begin m_cnt = 0; m_period = old_pn; end
      else m_cnt++;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.tu  = m_run && (m_cnt >= m_period / 2);
    e.sc  = 8'(((m_score / 10) << 4) | (m_score % 10));
    e.lv  = 2'(m_lives);
    e.go  = m_over;
    e.per = 32'(m_period);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, " timeUp"},     32'(timeUp),     32'(e.tu));
    check({tag, " score_bcd"},  32'(score_bcd),  32'(e.sc));
    check({tag, " lives"},      32'(lives),      32'(e.lv));
    check({tag, " game_over"},  32'(game_over),  32'(e.go));
    check({tag, " period_cur"}, period_cur,      e.per);
  endtask

  // Monitor: the DUT presents a new output after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_all("sb", e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic cycle(input bit en, input logic [1:0] a, input bit sh);
    @(posedge clk);
    #1;
    enable = en; add = a; shrink = sh;
    model_step(en, int'(a), sh);
    exp_q.push_back(model_out());
  endtask

  // Assert the reset between two edges and check the outputs before the next
  // edge. Then release the reset into IDLE.
  task automatic do_reset();
    @(posedge clk);
    #4;
    reset = 1'b1;
    #1;
    exp_q.delete();
    model_reset();
    check_all("async_reset", model_out());
    @(posedge clk);
    #3;
    enable = 1'b0; add = 2'd2; shrink = 1'b0;
    reset = 1'b0;
    model_step(0, 2, 0);
    exp_q.push_back(model_out());
  endtask

  initial begin
    int r;
    bit en;
    logic [1:0] a;
    model_reset();
    do_reset();

    // Free-running rounds with no events.
    repeat (20) cycle(1, 2'd2, 0);

    // Ten hits. Then run the score to 99 and keep hitting.
    for (int i = 0; i < 10; i++) begin
      cycle(1, 2'd1, 0);
      cycle(1, 2'd3, 0);
    end
    repeat (92) cycle(1, 2'd1, 0);

    // Shrink mid-round, then shrink repeatedly so the period reaches the floor.
    do_reset();
    cycle(1, 2'd2, 0);
    cycle(1, 2'd2, 0);
    cycle(1, 2'd2, 0);
    cycle(1, 2'd2, 1);
    repeat (12) cycle(1, 2'd2, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 2'd2, 1);
      repeat (5) cycle(1, 2'd2, 0);
    end
    repeat (16) cycle(1, 2'd2, 0);

    // Three misses lead to OVER. Hits and shrinks are ignored after that.
    for (int i = 0; i < 3; i++) begin
      cycle(1, 2'd0, 0);
      cycle(1, 2'd2, 0);
    end
    repeat (4) cycle(1, 2'd1, 1);

    // Restart, then apply a reset in the middle of a round.
    cycle(0, 2'd2, 0);
    cycle(1, 2'd2, 0);
    repeat (5) cycle(1, 2'd1, 0);
    do_reset();

    // Score 05 and two lives left. Drop enable, then re-enable.
    cycle(1, 2'd2, 0);
    repeat (5) cycle(1, 2'd1, 0);
    cycle(1, 2'd0, 0);
    repeat (3) cycle(0, 2'd2, 0);
    repeat (3) cycle(1, 2'd2, 0);

    // Random play.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      en = ($urandom_range(0, 99) != 0);
      r  = int'($urandom_range(0, 99));
      if (r < 3)       a = 2'd0;
      else if (r < 40) a = 2'd1;
      else if (r < 95) a = 2'd2;
      else             a = 2'd3;
      cycle(en, a, $urandom_range(0, 19) == 0);
    end

    @(posedge clk);
    #3;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
